stream_credit_tx: RTL and testbench

Credit-based transmitter that converts a local valid/ready stream into a valid/credit link toward a remote receive buffer of fixed depth. It sits at the sending end of a link whose far end is a buffer that cannot apply combinational backpressure. Instead, the far end returns one credit pulse per entry it frees. The block tracks outstanding credits, stalls the upstream stream when none remain, and registers every outgoing beat.

---
 rtl/stream_credit_tx.sv | 66 ++++++
 tb/tb_stream_credit_tx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/stream_credit_tx.sv
// Credit-based link transmitter: turns a valid/ready stream into a valid/credit link
// toward a remote buffer of CREDITS entries, with one registered output beat stage.
module stream_credit_tx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CREDITS    = 4,
    parameter int unsigned CNT_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_s,
    output logic                  ready_s,
    input  logic [DATA_WIDTH-1:0] data_s,
    output logic                  valid_m,
    output logic [DATA_WIDTH-1:0] data_m,
    input  logic                  credit_m,
    output logic [CNT_WIDTH-1:0]  credit_cnt,
    output logic                  credit_err
);

    localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(CREDITS);

    logic                 accept;
    logic                 at_full;
    logic                 overflow;
    logic [CNT_WIDTH-1:0] cnt_next;

    // ready_s depends only on the registered count and rst, never on valid_s or credit_m
    always_comb begin
        ready_s = (credit_cnt != '0) && !rst;
    end

    always_comb begin
        accept   = valid_s && ready_s;
        at_full  = (credit_cnt == FULL);
        overflow = 1'b0;
        cnt_next = credit_cnt;
        if (accept && !credit_m) begin
            cnt_next = credit_cnt - CNT_WIDTH'(1);
        end else if (!accept && credit_m) begin
            if (at_full) begin
                overflow = 1'b1;
            end else begin
                cnt_next = credit_cnt + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_m    <= 1'b0;
            data_m     <= '0;
            credit_cnt <= FULL;
            credit_err <= 1'b0;
        end else begin
            valid_m    <= accept;
            credit_cnt <= cnt_next;
            if (accept) begin
                data_m <= data_s;
            end
            if (overflow) begin
                credit_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_credit_tx.sv
// Directed bench for stream_credit_tx: a credit model plus a scoreboard queue of
// accepted payloads checks every link beat, the counter, ready_s and credit_err.
module tb_stream_credit_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid_s;
    logic       ready_s;
    logic [7:0] data_s;
    logic       valid_m;
    logic [7:0] data_m;
    logic       credit_m;
    logic [2:0] credit_cnt;
    logic       credit_err;

    stream_credit_tx #(
        .DATA_WIDTH(8),
        .CREDITS(4),
        .CNT_WIDTH(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .valid_s(valid_s),
        .ready_s(ready_s),
        .data_s(data_s),
        .valid_m(valid_m),
        .data_m(data_m),
        .credit_m(credit_m),
        .credit_cnt(credit_cnt),
        .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;
    int unsigned n_beats = 0;

    logic [7:0] sb_q[$];
    int unsigned m_cnt = 4;
    logic        m_err = 1'b0;
    logic        m_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: update the model from inputs seen at the edge, then check outputs #1 later.
    task automatic cyc();
        logic pre_rst;
        logic pre_cr;
        logic [7:0] exp_d;
        pre_rst = rst;
        pre_cr  = credit_m;
        m_acc   = valid_s && (m_cnt != 0) && !rst;
        if (m_acc) sb_q.push_back(data_s);
        @(posedge clk);
        #1;
        if (pre_rst) begin
            m_cnt = 4;
            m_err = 1'b0;
        end else if (m_acc && !pre_cr) begin
            m_cnt = m_cnt - 1;
        end else if (!m_acc && pre_cr) begin
            if (m_cnt == 4) m_err = 1'b1;
            else            m_cnt = m_cnt + 1;
        end
        check("valid_m", 32'(valid_m), 32'(m_acc));
        if (valid_m === 1'b1) begin
            n_beats++;
            if (sb_q.size() > 0) begin
                exp_d = sb_q.pop_front();
                check("data_m", 32'(data_m), 32'(exp_d));
            end else begin
                check("extra_beat", 32'(1), 32'(0));
            end
        end
        if (pre_rst) check("rst_data_m", 32'(data_m), 32'(0));
        check("credit_cnt", 32'(credit_cnt), 32'(m_cnt));
        check("credit_err", 32'(credit_err), 32'(m_err));
        check("ready_s", 32'(ready_s), 32'((m_cnt != 0) && !rst));
    endtask

    initial begin
        logic [7:0] nxt;

        // Reset held 3 cycles with valid_s and credit_m asserted
        rst = 1'b1; valid_s = 1'b1; credit_m = 1'b1; data_s = 8'hAA;
        for (int i = 0; i < 3; i++) cyc();
        rst = 1'b0; valid_s = 1'b0; credit_m = 1'b0;
        #1;
        check("rel_cnt", 32'(credit_cnt), 32'(4));
        check("rel_ready", 32'(ready_s), 32'(1));
        check("rel_beats", 32'(n_beats), 32'(0));

        // Credit exhaustion: offer 0x10..0x15, data held until accepted
        nxt = 8'h10;
        valid_s = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_s = nxt;
            cyc();
            if (m_acc) nxt = nxt + 8'h01;
        end
        check("exh_cnt", 32'(credit_cnt), 32'(0));
        check("exh_ready", 32'(ready_s), 32'(0));
        check("exh_beats", 32'(n_beats), 32'(4));
        check("exh_held", 32'(nxt), 32'(8'h14));

        // Resume: two credit pulses while 0x14/0x15 are offered
        data_s = nxt; credit_m = 1'b1;
        cyc();
        check("res_cnt1", 32'(credit_cnt), 32'(1));
        check("res_ready", 32'(ready_s), 32'(1));
        for (int i = 0; i < 4; i++) begin
            if (i >= 1) credit_m = 1'b0;
            data_s = nxt;
            cyc();
            if (m_acc) nxt = nxt + 8'h01;
            if (nxt == 8'h16) valid_s = 1'b0;
        end
        valid_s = 1'b0;
        cyc();
        check("res_beats", 32'(n_beats), 32'(6));
        check("res_q_empty", 32'(sb_q.size()), 32'(0));

        // Simultaneous accept and credit at cnt=1, 10 cycles
        credit_m = 1'b1;
        while (m_cnt != 1) cyc();
        check("sim_start_cnt", 32'(credit_cnt), 32'(1));
        for (int i = 0; i < 10; i++) begin
            valid_s = 1'b1; credit_m = 1'b1; data_s = 8'(8'h20 + i);
            cyc();
            check("sim_cnt", 32'(credit_cnt), 32'(1));
            check("sim_ready", 32'(ready_s), 32'(1));
        end
        valid_s = 1'b0; credit_m = 1'b0;
        cyc();
        check("sim_beats", 32'(n_beats), 32'(16));

        // Overflow: refill to 4, then one extra credit
        credit_m = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        check("ovf_full", 32'(credit_cnt), 32'(4));
        check("ovf_err0", 32'(credit_err), 32'(0));
        cyc();
        credit_m = 1'b0;
        check("ovf_cnt", 32'(credit_cnt), 32'(4));
        check("ovf_err1", 32'(credit_err), 32'(1));

        // Further traffic: err stays sticky; ends at cnt=2 with an accept just before
        valid_s = 1'b1;
        for (int i = 0; i < 2; i++) begin
            data_s = 8'(8'h30 + i);
            cyc();
        end
        check("mid_cnt2", 32'(credit_cnt), 32'(2));
        check("mid_err", 32'(credit_err), 32'(1));
        check("mid_vm", 32'(valid_m), 32'(1));

        // Reset for one cycle mid-burst, valid_s and credit_m still asserted
        rst = 1'b1; credit_m = 1'b1; data_s = 8'h3F;
        cyc();
        rst = 1'b0; valid_s = 1'b0; credit_m = 1'b0;
        check("mrst_vm", 32'(valid_m), 32'(0));
        check("mrst_cnt", 32'(credit_cnt), 32'(4));
        check("mrst_err", 32'(credit_err), 32'(0));
        cyc();
        cyc();
        check("final_q_empty", 32'(sb_q.size()), 32'(0));
        check("final_beats", 32'(n_beats), 32'(18));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
